// File: rtl/fixed_div_seq_if.sv
// rtl/fixed_div_seq_if.sv - operand/result handshake bundle for fixed_div_seq
interface fixed_div_seq_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;
    logic         div_by_zero;
    logic         overflow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, div_by_zero, overflow
    );
endinterface

// File: rtl/fixed_div_seq.sv
// rtl/fixed_div_seq.sv - sign-magnitude restoring divider, one quotient bit per clock
// Define FIXED_DIV_ROUND_EN for a guard iteration with round-half-up; otherwise truncate.
module fixed_div_seq #(
    parameter int N = 32,
    parameter int Q = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fixed_div_seq_if.slave    bus
);
    localparam int QW = N - 1 + Q;
`ifdef FIXED_DIV_ROUND_EN
    localparam int K  = QW + 1;
`else
    localparam int K  = QW;
`endif
    localparam int CW = $clog2(K + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e        state_q, state_d;
    logic          sign_q, sign_d;
    logic [K-1:0]  dvd_q, dvd_d;
    logic [N-2:0]  div_q, div_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [K-1:0]  quo_q, quo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  c_q, c_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;

    logic [N-1:0]  rem_sh, rem_nx;
    logic          ge;
    logic [K-1:0]  quo_nx;
    logic [QW:0]   mag_ext;
    logic          sat;
    logic [N-2:0]  mag;

    always_comb begin
        rem_sh = {rem_q[N-2:0], dvd_q[K-1]};
        ge     = (rem_sh >= {1'b0, div_q});
        rem_nx = ge ? (rem_sh - {1'b0, div_q}) : rem_sh;
        quo_nx = {quo_q[K-2:0], ge};
`ifdef FIXED_DIV_ROUND_EN
        // The guard bit is the LSB; adding it rounds the magnitude half-up.
        mag_ext = {1'b0, quo_nx[K-1:1]} + {{QW{1'b0}}, quo_nx[0]};
`else
        mag_ext = {1'b0, quo_nx};
`endif
        sat = |mag_ext[QW:N-1];
        mag = sat ? {(N-1){1'b1}} : mag_ext[N-2:0];
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        dvd_d   = dvd_q;
        div_d   = div_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d = bus.a[N-1] ^ bus.b[N-1];
                    dvd_d  = {bus.a[N-2:0], {(K-(N-1)){1'b0}}};
                    div_d  = bus.b[N-2:0];
                    rem_d  = '0;
                    quo_d  = '0;
                    cnt_d  = CW'(K - 1);
                    if (bus.b[N-2:0] == '0) begin
                        state_d = DONE;
                        c_d     = {bus.a[N-1] ^ bus.b[N-1], {(N-1){1'b1}}};
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                dvd_d = {dvd_q[K-2:0], 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    // A zero magnitude never carries a sign.
                    c_d     = {sign_q & (|mag), mag};
                    ovf_d   = sat;
                    dbz_d   = 1'b0;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    c_d     = '0;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            dvd_q   <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            dvd_q   <= dvd_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.c           = c_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_fixed_div_seq.sv
// tb/tb_fixed_div_seq.sv - directed self-checking bench for fixed_div_seq
module tb_fixed_div_seq;
    localparam int N = 32;
    localparam int Q = 16;
`ifdef FIXED_DIV_ROUND_EN
    localparam int LAT = N + Q + 1;
    localparam logic [31:0] C_2_3 = 32'h0000AAAB;
`else
    localparam int LAT = N + Q;
    localparam logic [31:0] C_2_3 = 32'h0000AAAA;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fixed_div_seq_if #(.N(N)) bus ();

    fixed_div_seq #(.N(N), .Q(Q)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands for one accept edge, then count edges (accept edge = 1) until out_valid.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            bus.in_valid = 1'b0;
        end while (!bus.out_valid && lat < 200);
        if (lat >= 200) check("result_timeout", 32'(lat), 32'(LAT));
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("idle_out_valid", 32'(bus.out_valid), 32'd0);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);
        check("idle_flags", {30'd0, bus.div_by_zero, bus.overflow}, 32'd0);
    endtask

    task automatic div_chk(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_c, input logic exp_dbz, input logic exp_ovf,
                           input int exp_lat);
        int lat;
        issue(a, b, lat);
        check({tag, "_c"}, bus.c, exp_c);
        check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(exp_dbz));
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_ovf));
        if (exp_lat > 0) check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        take();
    endtask

    initial begin
        int lat;
        int seen;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_c", bus.c, 32'd0);
        check("rst_flags", {30'd0, bus.div_by_zero, bus.overflow}, 32'd0);
        rst_n = 1'b1;

        div_chk("six_by_two", 32'h00060000, 32'h00020000, 32'h00030000, 1'b0, 1'b0, LAT);
        div_chk("neg_one_by_four", 32'h80010000, 32'h00040000, 32'h80004000, 1'b0, 1'b0, LAT);
        div_chk("neg_zero", 32'h80000000, 32'h80010000, 32'h00000000, 1'b0, 1'b0, 0);
        div_chk("two_by_three", 32'h00020000, 32'h00030000, C_2_3, 1'b0, 1'b0, LAT);
        div_chk("div_zero", 32'h80010000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0, 1);

        // Overflow result held under backpressure.
        issue(32'h75300000, 32'h00008000, lat);
        check("ovf_lat", 32'(lat), 32'(LAT));
        for (int i = 0; i < 5; i++) begin
            check("hold_c", bus.c, 32'h7FFFFFFF);
            check("hold_ovf", 32'(bus.overflow), 32'd1);
            check("hold_dbz", 32'(bus.div_by_zero), 32'd0);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        take();

        // Reset in the middle of a calculation.
        @(negedge clk);
        bus.a        = 32'h00060000;
        bus.b        = 32'h00020000;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("calc_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (18) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_c", bus.c, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        check("abort_in_ready_after", 32'(bus.in_ready), 32'd1);
        div_chk("after_abort", 32'h00060000, 32'h00020000, 32'h00030000, 1'b0, 1'b0, LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/fixed_div_seq.md
# fixed_div_seq

Multi-cycle, parametrised sign-magnitude fixed-point divider, c = a / b, computing one quotient bit per clock by restoring long division. It is an exact-quotient successor to the combinational reciprocal-times-multiply divider. It serves neuron-model datapaths that need correct quotients across the full N/Q range, with explicit divide-by-zero and overflow reporting. A valid/ready handshake sits on both the operand side and the result side.

## Interface
- N, 32: total word width; bit N-1 is the sign, bits N-2:0 are the magnitude.
- Q, 16: fraction bits; 1 ≤ Q ≤ N-2.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands a, b present.
- in_ready  out  1  block can accept operands.
- a  in  N  dividend, sign-magnitude Q-format.
- b  in  N  divisor, sign-magnitude Q-format.
- out_valid  out  1  result c and flags are valid.
- out_ready  in  1  consumer accepts the result.
- c  out  N  quotient, sign-magnitude Q-format.
- div_by_zero  out  1  b magnitude was zero.
- overflow  out  1  quotient magnitude saturated.

## Operation
- States:
  - IDLE: in_ready=1.
  - CALC: iterating.
  - DONE: out_valid=1.
- IDLE → CALC on in_valid && in_ready. Capture the following:
  - sign = a[N-1]^b[N-1].
  - Dividend D = a[N-2:0] << Q, which is N-1+Q bits.
  - Divisor M = b[N-2:0].
  - Clear the partial remainder R (N bits) and the quotient register.
  - Load the iteration counter with K-1.
- IDLE → DONE directly when the captured b[N-2:0]==0. In that case c = {sign, all ones}, div_by_zero=1, overflow=0.
- CALC behaviour, each cycle:
  - R = {R, next MSB of D}.
  - If R ≥ M: R -= M and shift a 1 into the quotient; otherwise shift a 0.
  - Decrement the counter.
  - CALC → DONE after the cycle in which the counter is 0.
- Iteration count K = N-1+Q without the rounding option; the rounding option adds one guard iteration.
- Result formation on the CALC → DONE transition:
  - If any quotient bit above position N-2 is set: saturate the magnitude to all ones and set overflow=1.
  - Negative zero is normalised: if the magnitude is 0, c[N-1]=0.
- DONE → IDLE on out_ready. c and the flags hold stable while out_valid=1 && out_ready=0.
- Operands are not accepted while in CALC or DONE; in_ready=0 in both.
- a magnitude 0 with b nonzero produces c=0, with no flags raised.

## Timing
- Reset state: IDLE.
  - in_ready=1.
  - out_valid=0.
  - c=0.
  - div_by_zero=0.
  - overflow=0.
  - Internal registers are cleared.
- Reset asserted mid-CALC or mid-DONE aborts immediately: no result is produced, and outputs return to their reset values asynchronously.
- Latency is counted from the accept edge to the first cycle with out_valid=1:
  - Normal case: K+1 cycles, which is N+Q (48 for default parameters).
  - Divide-by-zero case: 1 cycle.
- Throughput: one division per K+2 cycles when out_ready is held high. The DONE → IDLE transition costs one cycle, during which in_ready rises.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid; both are registered state decodes.
- Flags are registered alongside c and clear on leaving DONE.

## Configuration
- FIXED_DIV_ROUND_EN
  - Defined: one extra guard iteration runs (K = N+Q). The magnitude is rounded half-up by adding the guard bit. A carry out of bit N-2 saturates and sets overflow. Latency increases by 1.
  - Undefined: the magnitude is truncated toward zero, and K = N-1+Q.

## Test plan
All scenarios use N=32, Q=16 and the default configuration unless stated.
- a=0x00060000 (6.0), b=0x00020000 (2.0) → c=0x00030000, no flags, out_valid exactly 48 cycles after accept.
- a=0x80010000 (-1.0), b=0x00040000 (4.0) → c=0x80004000; then a=0x80000000 (-0), b=0x80010000 → c=0x00000000.
- a=0x00020000 (2.0), b=0x00030000 (3.0):
  - Undefined FIXED_DIV_ROUND_EN → c=0x0000AAAA.
  - Defined FIXED_DIV_ROUND_EN → c=0x0000AAAB, latency 49.
- a=0x80010000, b=0x00000000 → c=0xFFFFFFFF, div_by_zero=1, out_valid 1 cycle after accept.
- a=0x75300000 (30000.0), b=0x00008000 (0.5) → c=0x7FFFFFFF, overflow=1.
- Backpressure: out_ready=0 for 5 cycles in DONE → c and flags hold, and in_ready=0 throughout. Then assert rst_n=0 at cycle 20 of a new CALC → out_valid never rises, in_ready=1 after release, and the next division is correct.
